// File: rtl/note_dispenser.sv
// Note dispenser: splits an approved amount greedily into 2000/500/100 notes within cassette stock,
// then feeds them one at a time over a fire/ack handshake while tracking the cassette inventory.
module note_dispenser #(
  parameter int                NOTE_W      = 8,
  parameter logic [NOTE_W-1:0] INIT_2000   = 8'd20,
  parameter logic [NOTE_W-1:0] INIT_500    = 8'd40,
  parameter logic [NOTE_W-1:0] INIT_100    = 8'd100,
  parameter logic [14:0]       MAX_AMOUNT  = 15'd20000,
  parameter int                ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [14:0]       amount,
  output logic              busy,
  output logic              note_fire,
  output logic [1:0]        note_sel,
  input  logic              note_ack,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [14:0]       dispensed,
  input  logic              refill,
  input  logic [1:0]        refill_sel,
  input  logic [NOTE_W-1:0] refill_cnt,
  output logic [NOTE_W-1:0] cnt_2000,
  output logic [NOTE_W-1:0] cnt_500,
  output logic [NOTE_W-1:0] cnt_100
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PLAN, S_DISPENSE, S_WAIT_ACK, S_DONE, S_FAIL
  } state_t;

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  state_t            state_reg, state_next;
  logic [14:0]       rem_reg, rem_next;
  logic [14:0]       disp_reg, disp_next;
  logic [1:0]        sel_reg, sel_next;
  logic [1:0]        err_reg, err_next;
  logic [TMR_W-1:0]  tmr_reg, tmr_next;
  logic [NOTE_W-1:0] cnt_reg  [3];
  logic [NOTE_W-1:0] cnt_next [3];
  logic [NOTE_W-1:0] plan_reg [3];
  logic [NOTE_W-1:0] plan_next[3];
  logic [2:0]        can_take;
  logic [1:0]        pick;

  // Index 0/1/2 maps to 2000/500/100 everywhere in this module.
  function automatic logic [14:0] denom(input logic [1:0] sel);
    case (sel)
      2'd0:    denom = 15'd2000;
      2'd1:    denom = 15'd500;
      default: denom = 15'd100;
    endcase
  endfunction

  function automatic logic [NOTE_W-1:0] init_cnt(input int idx);
    case (idx)
      0:       init_cnt = INIT_2000;
      1:       init_cnt = INIT_500;
      default: init_cnt = INIT_100;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_take
      assign can_take[gi] = (rem_reg >= denom(2'(gi))) && (plan_reg[gi] < cnt_reg[gi]);
    end
  endgenerate

  // Largest denomination still owed by the plan.
  always_comb begin
    pick = 2'd2;
    if (plan_reg[1] != '0) pick = 2'd1;
    if (plan_reg[0] != '0) pick = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      rem_reg   <= '0;
      disp_reg  <= '0;
      sel_reg   <= '0;
      err_reg   <= '0;
      tmr_reg   <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_reg[i]  <= init_cnt(i);
        plan_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      disp_reg  <= disp_next;
      sel_reg   <= sel_next;
      err_reg   <= err_next;
      tmr_reg   <= tmr_next;
      for (int i = 0; i < 3; i++) begin
        cnt_reg[i]  <= cnt_next[i];
        plan_reg[i] <= plan_next[i];
      end
    end
  end

  always_comb begin
    logic more;
    more       = 1'b0;
    state_next = state_reg;
    rem_next   = rem_reg;
    disp_next  = disp_reg;
    sel_next   = sel_reg;
    err_next   = err_reg;
    tmr_next   = tmr_reg;
    for (int i = 0; i < 3; i++) begin
      cnt_next[i]  = cnt_reg[i];
      plan_next[i] = plan_reg[i];
    end

    case (state_reg)
      S_IDLE: begin
        if (req) begin
          rem_next   = amount;
          disp_next  = '0;
          err_next   = 2'd0;
          state_next = S_CHECK;
        end else if (refill) begin
          for (int i = 0; i < 3; i++)
            if (refill_sel == 2'(i)) cnt_next[i] = refill_cnt;
        end
      end
      S_CHECK: begin
        if (rem_reg == '0 || rem_reg > MAX_AMOUNT) begin
          err_next   = 2'd1;
          state_next = S_FAIL;
        end else begin
          for (int i = 0; i < 3; i++) plan_next[i] = '0;
          state_next = S_PLAN;
        end
      end
      S_PLAN: begin
        if (can_take[0]) begin
          rem_next     = rem_reg - denom(2'd0);
          plan_next[0] = plan_reg[0] + 1'b1;
        end else if (can_take[1]) begin
          rem_next     = rem_reg - denom(2'd1);
          plan_next[1] = plan_reg[1] + 1'b1;
        end else if (can_take[2]) begin
          rem_next     = rem_reg - denom(2'd2);
          plan_next[2] = plan_reg[2] + 1'b1;
        end else if (rem_reg == '0) begin
          state_next = S_DISPENSE;
        end else begin
          // A sub-100 residue can never be paid out; anything larger is a stock shortage.
          err_next   = (rem_reg < 15'd100) ? 2'd1 : 2'd2;
          state_next = S_FAIL;
        end
      end
      S_DISPENSE: begin
        sel_next   = pick;
        tmr_next   = '0;
        state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (note_ack) begin
          for (int i = 0; i < 3; i++) begin
            if (sel_reg == 2'(i)) begin
              cnt_next[i]  = cnt_reg[i] - 1'b1;
              plan_next[i] = plan_reg[i] - 1'b1;
            end
            if (plan_next[i] != '0) more = 1'b1;
          end
          disp_next  = disp_reg + denom(sel_reg);
          state_next = more ? S_DISPENSE : S_DONE;
        end else if (tmr_reg == TMR_W'(ACK_TIMEOUT - 1)) begin
          for (int i = 0; i < 3; i++) plan_next[i] = '0;
          err_next   = 2'd3;
          state_next = S_FAIL;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_FAIL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy      = (state_reg != S_IDLE);
  assign note_fire = (state_reg == S_DISPENSE);
  assign note_sel  = (state_reg == S_DISPENSE) ? pick : sel_reg;
  assign done      = (state_reg == S_DONE);
  assign error     = (state_reg == S_FAIL);
  assign err_code  = err_reg;
  assign dispensed = disp_reg;
  assign cnt_2000  = cnt_reg[0];
  assign cnt_500   = cnt_reg[1];
  assign cnt_100   = cnt_reg[2];

endmodule

// File: tb/tb_note_dispenser.sv
// Scoreboard bench for note_dispenser: stimulus pushes expected fires/results from a greedy
// arithmetic model, an ack driver answers the feed, and a monitor pops and compares.
module tb_note_dispenser;

  typedef struct {
    bit ok;
    int code;
    int disp;
    int c0;
    int c1;
    int c2;
  } res_t;

  logic        clk;
  logic        reset;
  logic        req;
  logic [14:0] amount;
  logic        busy;
  logic        note_fire;
  logic [1:0]  note_sel;
  logic        note_ack;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [14:0] dispensed;
  logic        refill;
  logic [1:0]  refill_sel;
  logic [7:0]  refill_cnt;
  logic [7:0]  cnt_2000;
  logic [7:0]  cnt_500;
  logic [7:0]  cnt_100;

  int   checks;
  int   errors;
  int   mcnt[3];
  int   den[3];
  int   jam_idx;
  int   last_code;
  int   fire_q[$];
  res_t res_q[$];

  note_dispenser dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .amount     (amount),
    .busy       (busy),
    .note_fire  (note_fire),
    .note_sel   (note_sel),
    .note_ack   (note_ack),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .dispensed  (dispensed),
    .refill     (refill),
    .refill_sel (refill_sel),
    .refill_cnt (refill_cnt),
    .cnt_2000   (cnt_2000),
    .cnt_500    (cnt_500),
    .cnt_100    (cnt_100)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endfunction

  function automatic void model_init();
    mcnt[0]   = 20;
    mcnt[1]   = 40;
    mcnt[2]   = 100;
    last_code = 0;
    jam_idx   = -1;
  endfunction

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt_2000"}, int'(cnt_2000), mcnt[0]);
    chk({tag, "_cnt_500"},  int'(cnt_500),  mcnt[1]);
    chk({tag, "_cnt_100"},  int'(cnt_100),  mcnt[2]);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_init();
    fire_q.delete();
    res_q.delete();
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", cyc);
      reset_dut();
    end
  endtask

  task automatic do_refill(input logic [1:0] sel, input int cnt);
    refill     = 1'b1;
    refill_sel = sel;
    refill_cnt = 8'(cnt);
    @(negedge clk);
    refill = 1'b0;
    if (sel != 2'd3) mcnt[sel] = cnt;
    chk_counts("refill");
  endtask

  // jam: -1 none, -2 random note, >=0 that note index is never acknowledged.
  task automatic issue(input int amt, input int jam, input bit refill_same, input bit refill_busy);
    int   n[3];
    int   r, code, j, nfire, nack;
    int   notes[$];
    res_t e;
    chk("err_code_held", int'(err_code), last_code);
    r    = amt;
    code = 0;
    if (amt == 0 || amt > 20000) begin
      code = 1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        n[i] = r / den[i];
        if (n[i] > mcnt[i]) n[i] = mcnt[i];
        r -= n[i] * den[i];
        for (int k = 0; k < n[i]; k++) notes.push_back(i);
      end
      if (r != 0) code = (r < 100) ? 1 : 2;
    end
    if (code != 0) notes.delete();
    j = -1;
    if (code == 0 && jam != -1)
      j = (jam == -2) ? int'($urandom_range(0, notes.size() - 1)) : jam;
    jam_idx = j;
    nack  = (j < 0) ? notes.size() : j;
    nfire = (j < 0) ? notes.size() : j + 1;
    e.disp = 0;
    for (int k = 0; k < nfire; k++) fire_q.push_back(notes[k]);
    for (int k = 0; k < nack; k++) begin
      mcnt[notes[k]]--;
      e.disp += den[notes[k]];
    end
    e.ok   = (code == 0 && j < 0);
    e.code = (j >= 0) ? 3 : code;
    e.c0   = mcnt[0];
    e.c1   = mcnt[1];
    e.c2   = mcnt[2];
    res_q.push_back(e);
    last_code = e.code;

    req    = 1'b1;
    amount = 15'(amt);
    if (refill_same) begin
      refill     = 1'b1;
      refill_sel = 2'($urandom_range(0, 2));
      refill_cnt = '0;
    end
    @(negedge clk);
    req    = 1'b0;
    refill = 1'b0;
    if (refill_busy) begin
      refill     = 1'b1;
      refill_sel = 2'($urandom_range(0, 2));
      refill_cnt = '0;
      @(negedge clk);
      refill = 1'b0;
    end
    wait_idle();
  endtask

  // Withhold the first ack of a 2500 request and pull reset while the feed is waiting.
  task automatic reset_mid();
    int cyc;
    cyc = 0;
    chk("err_code_held", int'(err_code), last_code);
    jam_idx = 0;
    fire_q.push_back(0);
    req    = 1'b1;
    amount = 15'd2500;
    @(negedge clk);
    req = 1'b0;
    while (!note_fire && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("fire_before_reset", int'(note_fire), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy",      int'(busy),      0);
    chk("midreset_err_code",  int'(err_code),  0);
    chk("midreset_dispensed", int'(dispensed), 0);
    chk("midreset_cnt_2000",  int'(cnt_2000),  20);
    chk("midreset_cnt_500",   int'(cnt_500),   40);
    chk("midreset_cnt_100",   int'(cnt_100),   100);
    reset = 1'b0;
    model_init();
  endtask

  // Ack driver: answers each fire after 1..4 cycles, occasionally exactly at the timeout cycle.
  initial begin
    int cd;
    int idx;
    cd       = 0;
    idx      = 0;
    note_ack = 1'b0;
    forever begin
      @(negedge clk);
      note_ack = 1'b0;
      if (!busy || reset) begin
        cd  = 0;
        idx = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) note_ack = 1'b1;
        end
        if (note_fire) begin
          if (idx != jam_idx)
            cd = ($urandom_range(0, 7) == 0) ? 16 : int'($urandom_range(1, 4));
          idx++;
        end
      end
    end
  end

  // Monitor: pops expected fires and results whenever the DUT presents them.
  initial begin
    res_t e;
    int   s;
    int   ntx;
    ntx = 0;
    forever begin
      @(negedge clk);
      if (note_fire) begin
        if (fire_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fire_unexpected: note_sel=%0d fired, required no fire", note_sel);
        end else begin
          s = fire_q.pop_front();
          chk("note_sel", int'(note_sel), s);
        end
      end
      if (done || error) begin
        ntx++;
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_unexpected: done=%0d error=%0d, required no completion", done, error);
        end else begin
          e = res_q.pop_front();
          chk("done",      int'(done),      int'(e.ok));
          chk("error",     int'(error),     int'(!e.ok));
          chk("err_code",  int'(err_code),  e.code);
          chk("dispensed", int'(dispensed), e.disp);
          chk("cnt_2000",  int'(cnt_2000),  e.c0);
          chk("cnt_500",   int'(cnt_500),   e.c1);
          chk("cnt_100",   int'(cnt_100),   e.c2);
        end
        $display("txn %0d: done=%0d error=%0d err_code=%0d dispensed=%0d cnt=%0d/%0d/%0d",
                 ntx, done, error, err_code, dispensed, cnt_2000, cnt_500, cnt_100);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int amt;
    checks     = 0;
    errors     = 0;
    den[0]     = 2000;
    den[1]     = 500;
    den[2]     = 100;
    reset      = 1'b1;
    req        = 1'b0;
    amount     = '0;
    refill     = 1'b0;
    refill_sel = '0;
    refill_cnt = '0;
    model_init();
    repeat (3) @(negedge clk);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_note_fire", int'(note_fire), 0);
    chk("rst_done",      int'(done),      0);
    chk("rst_error",     int'(error),     0);
    chk("rst_note_sel",  int'(note_sel),  0);
    chk("rst_err_code",  int'(err_code),  0);
    chk("rst_dispensed", int'(dispensed), 0);
    chk_counts("rst");
    reset = 1'b0;
    @(negedge clk);

    issue(2600, -1, 1'b0, 1'b0);
    issue(650, -1, 1'b0, 1'b0);
    issue(0, -1, 1'b0, 1'b0);
    issue(20100, -1, 1'b0, 1'b0);
    issue(20000, -1, 1'b0, 1'b0);
    do_refill(2'd2, 0);
    do_refill(2'd1, 1);
    issue(1100, -1, 1'b0, 1'b0);
    issue(4500, 2, 1'b0, 1'b0);
    do_refill(2'd0, 20);
    do_refill(2'd1, 40);
    do_refill(2'd2, 100);
    reset_mid();
    issue(2600, -1, 1'b1, 1'b1);
    do_refill(2'd3, 0);
    issue(700, -1, 1'b0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0)
        do_refill(2'($urandom_range(0, 3)), int'($urandom_range(0, 60)));
      case ($urandom_range(0, 9))
        0:       amt = 0;
        1:       amt = int'($urandom_range(20001, 32767));
        2:       amt = int'($urandom_range(1, 20000));
        3:       amt = 20000;
        default: amt = 100 * int'($urandom_range(1, 60));
      endcase
      issue(amt, ($urandom_range(0, 5) == 0) ? -2 : -1,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    repeat (5) @(negedge clk);
    chk("fire_q_drained", fire_q.size(), 0);
    chk("res_q_drained",  res_q.size(),  0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_dispenser.md
Name: note_dispenser

Overview:
Downstream stage of the ATM controller. Accepts an approved withdrawal amount and breaks it greedily into 2000/500/100 notes, limited by cassette stock. It then drives the note-feed mechanism one note at a time with a fire/ack handshake, and reports completion, dispensed total or error back to the controller. It owns the cassette inventory counters, including refill.

Parameters:
NOTE_W, 8, width of each cassette count
INIT_2000, 8'd20, cassette count for 2000-notes after reset
INIT_500, 8'd40, cassette count for 500-notes after reset
INIT_100, 8'd100, cassette count for 100-notes after reset
MAX_AMOUNT, 15'd20000, largest single request accepted
ACK_TIMEOUT, 16, cycles to wait for note_ack before declaring a jam

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
req  in  1  start request; sampled only in IDLE
amount  in  15  requested amount, captured when req is accepted
busy  out  1  high in every state except IDLE
note_fire  out  1  one-cycle pulse: feed one note of type note_sel
note_sel  out  2  note type: 0=2000, 1=500, 2=100 (3 never driven)
note_ack  in  1  mechanism confirms the note was delivered
done  out  1  one-cycle pulse on successful completion
error  out  1  one-cycle pulse on failure
err_code  out  2  0=none, 1=invalid amount, 2=insufficient notes, 3=jam; held until next accepted req
dispensed  out  15  value actually delivered for last/current request
refill  in  1  load cassette refill_sel with refill_cnt; honoured only in IDLE
refill_sel  in  2  cassette select for refill (3 ignored)
refill_cnt  in  NOTE_W  new count for selected cassette
cnt_2000, cnt_500, cnt_100  out  NOTE_W each  live cassette inventory

Behaviour:
- Reset: state=IDLE; busy, note_fire, done, error = 0; note_sel=0; err_code=0; dispensed=0; cassettes = INIT_*. Plan registers and remainder cleared. Reset mid-dispense aborts immediately; cassettes return to INIT_* values.
- IDLE: on req=1, capture amount into rem, clear dispensed and err_code, then go to CHECK. If req and refill are high in the same cycle, refill is ignored and req wins. A refill with refill_sel=3 has no effect.
- CHECK (1 cycle): if amount==0 or amount>MAX_AMOUNT, go to FAIL with code 1. Otherwise go to PLAN with plan counts p2000/p500/p100=0.
- PLAN: performs one subtraction per cycle, with no divider.
  - Priority: if rem>=2000 and p2000<cnt_2000, then rem-=2000 and p2000++. Else if rem>=500 and p500<cnt_500, then rem-=500 and p500++. Else if rem>=100 and p100<cnt_100, then rem-=100 and p100++. Else the plan ends.
  - At plan end: if rem==0, go to DISPENSE. If rem is 1..99, go to FAIL with code 1. If rem>=100, go to FAIL with code 2.
  - No note is fired on any failure path. Worst-case PLAN length is MAX_AMOUNT/100+1 cycles.
- DISPENSE: pick the highest type with a nonzero plan count. Pulse note_fire for exactly 1 cycle with note_sel set, then go to WAIT_ACK with the timer cleared.
- WAIT_ACK:
  - note_ack while in WAIT_ACK → decrement that cassette and its plan count, add the denomination to dispensed. If plan counts are still nonzero, return to DISPENSE; else go to DONE. note_ack outside WAIT_ACK is ignored.
  - Timer reaches ACK_TIMEOUT with no ack → go to FAIL with code 3. The remaining plan is discarded, and cassettes and dispensed reflect only acknowledged notes.
  - note_ack arriving on the same cycle as the timeout counts as an ack, not a jam.
- DONE: done=1 for 1 cycle, then IDLE. FAIL: error=1 for 1 cycle with err_code valid, then IDLE.
- Arithmetic: rem and dispensed are 15 bits unsigned. Denominations are fixed constants. Cassette decrements never underflow, because plan count is bounded by count at PLAN time and refill is blocked while busy.
- Minimum handshake spacing is 2 cycles per note (fire, ack), so the minimum gap between consecutive note_fire pulses is 2 cycles.

Test Plan:
- Reset, amount=2600, ack 1 cycle after each fire → fires sel 0,1,2 in order; done pulse; dispensed=2600; counts 19/39/99.
- amount=650 → error, err_code=1, no note_fire; amount=0 and amount=20100 → err_code=1.
- Refill cnt_100=0 and cnt_500=1, then amount=1100 → err_code=2, no fires, counts unchanged.
- amount=4500, ack first two notes, withhold third for 16 cycles → err_code=3; dispensed=4000; cnt_2000 down 2, cnt_500 unchanged.
- Assert reset during WAIT_ACK of amount=2500 → IDLE next cycle, busy=0, counts back to INIT_*, err_code=0.
- refill with req in the same cycle → request proceeds normally, cassette unchanged; refill while busy ignored; refill_sel=3 no effect.
